front_panel_sw: RTL and testbench
=================================

// Module: front_panel_sw
// PURPOSE
//  Front-panel switch conditioner feeding the console switch register (iopage 17570).
//  Synchronises and debounces the raw panel toggle switches and presents a stable
//  16-bit switches word plus a change strobe. Sits directly upstream of the
//  switch-register read path; that path only samples `switches`.
// PARAMETERS
//  NSW       16     number of switch inputs
//  TICK_DIV  50000  clk cycles per debounce sample tick (>=2)
//  STABLE    4      consecutive equal samples required to accept a new level (2..8)
// PORTS
//  clk          in   1    system clock
//  reset        in   1    asynchronous, active-low reset (asserted when 0)
//  sw_raw       in   NSW  raw panel switches, asynchronous, bouncy
//  switches     out  NSW  debounced switch word, to switch register
//  sw_changed   out  1    one-cycle pulse when `switches` takes a new value
//  tick         out  1    one-cycle debug pulse at each sample tick
//  ovr_wr       in   1    (FP_SW_OVERRIDE_EN only) load override word
//  ovr_data     in   NSW  (FP_SW_OVERRIDE_EN only) override word
//  ovr_clr      in   1    (FP_SW_OVERRIDE_EN only) release override
//  ovr_active   out  1    (FP_SW_OVERRIDE_EN only) override in force
// BEHAVIOUR
//  - Reset (reset==0, async): sync flops, prescaler, sample histories cleared to 0;
//    switches=0, sw_changed=0, tick=0, ovr_active=0. Release is synchronous to clk.
//  - Synchroniser: 2-flop per bit on sw_raw; sync value lags sw_raw by 2 clks.
//  - Prescaler: counts 0..TICK_DIV-1, wraps to 0; tick=1 in the cycle count==TICK_DIV-1.
//    First tick after reset at cycle TICK_DIV.
//  - Per bit, on tick: shift synced bit into STABLE-deep history. If all STABLE bits
//    are 1 the debounced bit becomes 1, all 0 -> 0, otherwise hold. Update is
//    registered: visible on switches the cycle after the deciding tick.
//  - Latency: a clean level change is accepted at the STABLE-th tick that samples it;
//    worst case 2 + STABLE*TICK_DIV + 1 clks. Glitches lasting < STABLE ticks never
//    reach switches. Bits are independent; several bits may change on one tick.
//  - sw_changed: asserted one cycle, coincident with the cycle switches first shows a
//    new value; never asserted when value is unchanged (incl. reset release).
//  - Reset mid-debounce discards partial history; after release sw_raw must again be
//    stable STABLE ticks before switches follows.
// CONFIGURATION
//  FP_SW_OVERRIDE_EN defined: ovr_* ports exist. ovr_wr=1 -> next cycle switches=ovr_data,
//    ovr_active=1, sw_changed if value differs. Debounce keeps running in background.
//    ovr_clr=1 -> next cycle switches=current debounced word, ovr_active=0, sw_changed
//    if differs. ovr_wr and ovr_clr same cycle: ovr_wr wins. ovr_wr while active reloads.
//  FP_SW_OVERRIDE_EN undefined: ovr_* ports absent; switches always debounced word.
// STRUCTURE
//  - Shared include fp_defs.vh: FP_NSW (16), FP_TICK_DIV default, FP_STABLE default,
//    switch-register iopage address constant 13'o17570.
//  - Sub-module sw_debounce_bit (sync + history + debounced flop, one bit), instantiated
//    NSW times by generate; prescaler, change detect and override mux in the top.
// TESTING (bench uses TICK_DIV=4, STABLE=3)
//  1. Reset held, sw_raw=16'o177777 -> switches=0, sw_changed=0; release -> switches=
//     16'o177777 within 2+3*4+1=15 clks, exactly one sw_changed pulse.
//  2. Stable 16'o000000, bit0 toggles 1 for 2 ticks then back -> switches stays 0,
//     no sw_changed.
//  3. sw_raw 16'o000000 -> 16'o125252 clean step -> switches=16'o125252 after 3rd
//     sampling tick +1 clk; single sw_changed.
//  4. Assert reset mid-debounce (after 2 ticks of new value) -> switches=0 immediately;
//     after release needs full 3 ticks again.
//  5. (FP_SW_OVERRIDE_EN) ovr_wr with 16'o007777 -> next clk switches=16'o007777,
//     ovr_active=1; raw changes ignored; ovr_clr -> debounced value, ovr_active=0.
//  6. (FP_SW_OVERRIDE_EN) ovr_wr and ovr_clr same cycle, ovr_data=16'o000001 ->
//     switches=16'o000001, ovr_active=1.

Source files
------------

// File: rtl/front_panel_sw_pkg.sv
// Shared constants for the front-panel switch conditioner.
//
// Contents:
//   FP_NSW       width of the panel switch word
//   FP_TICK_DIV  default clk cycles per debounce sample tick
//   FP_STABLE    default number of equal samples needed to accept a level
//   FP_SWR_ADDR  iopage address of the console switch register fed by this block
package front_panel_sw_pkg;

  localparam int          FP_NSW      = 16;
  localparam int          FP_TICK_DIV = 50000;
  localparam int          FP_STABLE   = 4;
  localparam logic [12:0] FP_SWR_ADDR = 13'o17570;

endpackage

// File: rtl/front_panel_sw_debounce_bit.sv
// sw_debounce_bit: conditioner for one raw panel switch.
//
// Brings the asynchronous switch into the clk domain with a two-flop
// synchroniser, shifts the synchronised level into a STABLE-deep history on
// every sample strobe, and updates the debounced level only when the whole
// history agrees. A mixed history leaves the level unchanged.
//
// Ports:
//   clk     in  system clock
//   reset   in  asynchronous reset, active low
//   raw     in  raw switch, asynchronous and bouncy
//   sample  in  one-cycle sample strobe from the shared prescaler
//   level   out registered debounced level
module sw_debounce_bit
  import front_panel_sw_pkg::*;
#(
  parameter int STABLE = FP_STABLE
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic sample,
  output logic level
);

  logic              sync_a;
  logic              sync_b;
  logic [STABLE-1:0] hist;
  logic [STABLE-1:0] hist_next;

  // The decision looks at the history including the sample being taken now,
  // so a level is accepted on the STABLE-th agreeing tick, not one tick later.
  always_comb begin
    hist_next = {hist[STABLE-2:0], sync_b};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      hist   <= '0;
      level  <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      if (sample) begin
        hist <= hist_next;
        if (&hist_next) begin
          level <= 1'b1;
        end else if (~|hist_next) begin
          level <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/front_panel_sw.sv
// front_panel_sw: front-panel switch conditioner feeding the console switch
// register at iopage FP_SWR_ADDR.
//
// A shared prescaler produces a sample tick every TICK_DIV clocks. Each of the
// NSW switches is synchronised and debounced independently by sw_debounce_bit.
// The resulting word drives `switches`; sw_changed pulses in the first cycle
// `switches` shows a new value.
//
// Optional feature (macro FP_SW_OVERRIDE_EN): software override of the switch
// word. ovr_wr loads ovr_data and puts the override in force (it wins over
// ovr_clr in the same cycle); ovr_clr returns to the debounced word. The
// debouncers keep running while the override is in force.
//
// Ports:
//   clk         in  system clock
//   reset       in  asynchronous reset, active low
//   sw_raw      in  raw panel switches (NSW)
//   switches    out debounced / overridden switch word (NSW)
//   sw_changed  out one-cycle pulse when switches takes a new value
//   tick        out one-cycle pulse at each sample tick
//   ovr_wr      in  (FP_SW_OVERRIDE_EN) load override word
//   ovr_data    in  (FP_SW_OVERRIDE_EN) override word (NSW)
//   ovr_clr     in  (FP_SW_OVERRIDE_EN) release override
//   ovr_active  out (FP_SW_OVERRIDE_EN) override in force
module front_panel_sw
  import front_panel_sw_pkg::*;
#(
  parameter int NSW      = FP_NSW,
  parameter int TICK_DIV = FP_TICK_DIV,
  parameter int STABLE   = FP_STABLE
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NSW-1:0] sw_raw,
  output logic [NSW-1:0] switches,
  output logic           sw_changed,
  output logic           tick
`ifdef FP_SW_OVERRIDE_EN
  ,
  input  logic           ovr_wr,
  input  logic [NSW-1:0] ovr_data,
  input  logic           ovr_clr,
  output logic           ovr_active
`endif
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0]  div_cnt;
  logic [NSW-1:0] deb_word;
  logic [NSW-1:0] last_word;

  assign tick = (div_cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  for (genvar i = 0; i < NSW; i++) begin : g_bit
    sw_debounce_bit #(
      .STABLE (STABLE)
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .raw    (sw_raw[i]),
      .sample (tick),
      .level  (deb_word[i])
    );
  end

`ifdef FP_SW_OVERRIDE_EN
  logic           ovr_on;
  logic [NSW-1:0] ovr_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovr_on   <= 1'b0;
      ovr_word <= '0;
    end else if (ovr_wr) begin
      ovr_on   <= 1'b1;
      ovr_word <= ovr_data;
    end else if (ovr_clr) begin
      ovr_on   <= 1'b0;
    end
  end

  assign switches   = ovr_on ? ovr_word : deb_word;
  assign ovr_active = ovr_on;
`else
  assign switches = deb_word;
`endif

  // Remember what was presented last cycle; both copies clear together on
  // reset, so neither reset entry nor release produces a change pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_word <= '0;
    end else begin
      last_word <= switches;
    end
  end

  assign sw_changed = (switches != last_word);

endmodule

// File: tb/tb_front_panel_sw.sv
// Testbench for front_panel_sw with TICK_DIV=4, STABLE=3.
// Reference model tracks, per switch, the current run of equal samples and
// accepts a level once that run reaches STABLE samples.
module tb_front_panel_sw;

  localparam int TD = 4;
  localparam int ST = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] sw_raw = '0;
  logic [15:0] switches;
  logic        sw_changed;
  logic        tick;
`ifdef FP_SW_OVERRIDE_EN
  logic        ovr_wr = 1'b0;
  logic [15:0] ovr_data = '0;
  logic        ovr_clr = 1'b0;
  logic        ovr_active;
`endif

  int checks = 0;
  int errors = 0;

  front_panel_sw #(
    .NSW      (16),
    .TICK_DIV (TD),
    .STABLE   (ST)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_raw     (sw_raw),
    .switches   (switches),
    .sw_changed (sw_changed),
    .tick       (tick)
`ifdef FP_SW_OVERRIDE_EN
    ,
    .ovr_wr     (ovr_wr),
    .ovr_data   (ovr_data),
    .ovr_clr    (ovr_clr),
    .ovr_active (ovr_active)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural reference model
  logic [15:0] m_s1, m_s2, m_deb, m_prev, m_ovr_word;
  logic        m_ovr;
  int          m_cnt;
  int          run_len [16];
  logic        run_val [16];

  function automatic logic [15:0] exp_sw();
    return m_ovr ? m_ovr_word : m_deb;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_prev = '0;
      m_ovr = 1'b0; m_ovr_word = '0; m_cnt = 0;
      for (int i = 0; i < 16; i++) begin
        run_val[i] = 1'b0;
        run_len[i] = ST;
      end
    end else begin
      m_prev = exp_sw();
      if (m_cnt == TD - 1) begin
        for (int i = 0; i < 16; i++) begin
          if (m_s2[i] == run_val[i]) begin
            run_len[i] = (run_len[i] < ST) ? run_len[i] + 1 : ST;
          end else begin
            run_val[i] = m_s2[i];
            run_len[i] = 1;
          end
          if (run_len[i] == ST) m_deb[i] = run_val[i];
        end
      end
      m_s2 = m_s1;
      m_s1 = sw_raw;
      m_cnt = (m_cnt + 1) % TD;
`ifdef FP_SW_OVERRIDE_EN
      if (ovr_wr) begin
        m_ovr = 1'b1;
        m_ovr_word = ovr_data;
      end else if (ovr_clr) begin
        m_ovr = 1'b0;
      end
`endif
    end
  end

  task automatic test_reset();
    int pulses;
    int seen;
    reset = 1'b0;
    sw_raw = 16'o177777;
    repeat (3) @(negedge clk);
    checks++;
    if (switches !== 16'o000000) begin
      errors++; $display("FAIL reset_switches got %o want %o", switches, 16'o000000);
    end
    checks++;
    if (sw_changed !== 1'b0) begin
      errors++; $display("FAIL reset_changed got %b want 0", sw_changed);
    end
    checks++;
    if (tick !== 1'b0) begin
      errors++; $display("FAIL reset_tick got %b want 0", tick);
    end
`ifdef FP_SW_OVERRIDE_EN
    checks++;
    if (ovr_active !== 1'b0) begin
      errors++; $display("FAIL reset_ovr_active got %b want 0", ovr_active);
    end
`endif
    reset = 1'b1;
    pulses = 0;
    seen = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (sw_changed === 1'b1) pulses++;
      if (seen < 0 && switches === 16'o177777) seen = c;
      checks++;
      if (switches !== exp_sw()) begin
        errors++; $display("FAIL release_model cyc %0d got %o want %o", c, switches, exp_sw());
      end
    end
    checks++;
    if (seen < 0 || seen > 2 + ST * TD + 1) begin
      errors++; $display("FAIL release_latency got %0d want <= %0d", seen, 2 + ST * TD + 1);
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL release_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_glitch();
    int pulses;
    sw_raw = 16'o000000;
    repeat (20) @(negedge clk);
    checks++;
    if (switches !== 16'o000000) begin
      errors++; $display("FAIL glitch_settle got %o want %o", switches, 16'o000000);
    end
    pulses = 0;
    sw_raw = 16'o000001;
    for (int c = 0; c < 30; c++) begin
      if (c == 2 * TD) sw_raw = 16'o000000;
      @(negedge clk);
      if (sw_changed === 1'b1) pulses++;
      checks++;
      if (switches !== 16'o000000) begin
        errors++; $display("FAIL glitch_switches cyc %0d got %o want %o", c, switches, 16'o000000);
      end
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL glitch_pulses got %0d want 0", pulses);
    end
  endtask

  task automatic test_step();
    int pulses;
    int seen;
    pulses = 0;
    seen = -1;
    sw_raw = 16'o125252;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (sw_changed === 1'b1) pulses++;
      if (seen < 0 && switches === 16'o125252) seen = c;
      checks++;
      if (switches !== exp_sw() || sw_changed !== (exp_sw() != m_prev)) begin
        errors++;
        $display("FAIL step_model cyc %0d got %o/%b want %o/%b", c, switches, sw_changed,
                 exp_sw(), exp_sw() != m_prev);
      end
    end
    checks++;
    if (seen < 2 + (ST - 1) * TD + 1 || seen > 2 + ST * TD + 1) begin
      errors++; $display("FAIL step_latency got %0d want %0d..%0d", seen,
                         2 + (ST - 1) * TD + 1, 2 + ST * TD + 1);
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL step_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    sw_raw = 16'o177777;
    repeat (2 + 2 * TD) @(negedge clk);
    checks++;
    if (switches !== 16'o125252) begin
      errors++; $display("FAIL mid_hold got %o want %o", switches, 16'o125252);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (switches !== 16'o000000 || sw_changed !== 1'b0) begin
      errors++; $display("FAIL mid_async got %o/%b want %o/0", switches, sw_changed, 16'o000000);
    end
    @(negedge clk);
    reset = 1'b1;
    seen = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (seen < 0 && switches === 16'o177777) seen = c;
      checks++;
      if (switches !== exp_sw()) begin
        errors++; $display("FAIL mid_model cyc %0d got %o want %o", c, switches, exp_sw());
      end
    end
    checks++;
    if (seen != ST * TD) begin
      errors++; $display("FAIL mid_latency got %0d want %0d", seen, ST * TD);
    end
  endtask

`ifdef FP_SW_OVERRIDE_EN
  task automatic test_override();
    ovr_data = 16'o007777;
    ovr_wr = 1'b1;
    @(negedge clk);
    ovr_wr = 1'b0;
    checks++;
    if (switches !== 16'o007777 || ovr_active !== 1'b1 || sw_changed !== 1'b1) begin
      errors++; $display("FAIL ovr_load got %o/%b/%b want %o/1/1", switches, ovr_active,
                         sw_changed, 16'o007777);
    end
    sw_raw = 16'o052525;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      checks++;
      if (switches !== 16'o007777) begin
        errors++; $display("FAIL ovr_hold cyc %0d got %o want %o", c, switches, 16'o007777);
      end
    end
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    checks++;
    if (switches !== 16'o052525 || ovr_active !== 1'b0 || sw_changed !== 1'b1) begin
      errors++; $display("FAIL ovr_clear got %o/%b/%b want %o/0/1", switches, ovr_active,
                         sw_changed, 16'o052525);
    end
  endtask

  task automatic test_ovr_both();
    ovr_data = 16'o000001;
    ovr_wr = 1'b1;
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_wr = 1'b0;
    ovr_clr = 1'b0;
    checks++;
    if (switches !== 16'o000001 || ovr_active !== 1'b1) begin
      errors++; $display("FAIL ovr_both got %o/%b want %o/1", switches, ovr_active, 16'o000001);
    end
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    checks++;
    if (ovr_active !== 1'b0 || switches !== exp_sw()) begin
      errors++; $display("FAIL ovr_both_clear got %o/%b want %o/0", switches, ovr_active, exp_sw());
    end
  endtask
`endif

  task automatic test_random();
    int hold;
    hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold == 0) begin
        if ($urandom_range(1, 0) == 1) sw_raw = 16'($urandom);
        else sw_raw = sw_raw ^ (16'h1 << $urandom_range(15, 0));
        hold = $urandom_range(20, 1);
      end
      hold--;
`ifdef FP_SW_OVERRIDE_EN
      ovr_wr = ($urandom_range(39, 0) == 0);
      ovr_clr = ($urandom_range(29, 0) == 0);
      ovr_data = 16'($urandom);
`endif
      @(negedge clk);
      checks++;
      if (switches !== exp_sw() || sw_changed !== (exp_sw() != m_prev) ||
          tick !== (m_cnt == TD - 1)) begin
        errors++;
        $display("FAIL random cyc %0d got %o/%b/%b want %o/%b/%b", c, switches, sw_changed,
                 tick, exp_sw(), exp_sw() != m_prev, m_cnt == TD - 1);
      end
`ifdef FP_SW_OVERRIDE_EN
      checks++;
      if (ovr_active !== m_ovr) begin
        errors++; $display("FAIL random_ovr cyc %0d got %b want %b", c, ovr_active, m_ovr);
      end
`endif
    end
`ifdef FP_SW_OVERRIDE_EN
    ovr_wr = 1'b0;
    ovr_clr = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_step();
    test_reset_mid();
`ifdef FP_SW_OVERRIDE_EN
    test_override();
    test_ovr_both();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
